// File: rtl/game_autoplayer.sv
// Autoplayer for the motivation game: watches the game's state code, tracks one-shot
// actions and drives a registered Decision that steers the game toward the win state.
module game_autoplayer #(
    parameter int TARGET_MOT = 7,
    parameter int MOT_W      = 3,
    parameter int MAX_STEPS  = 63
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       state,
    output logic [1:0]       Decision,
    output logic [MOT_W-1:0] motivation,
    output logic             done,
    output logic             win,
    output logic             timeout
);
    localparam int STEP_W = $clog2(MAX_STEPS + 1);

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_PLAY = 2'd1;
    localparam logic [1:0] PH_DONE = 2'd2;

    localparam logic [1:0] DEC_A = 2'b00;
    localparam logic [1:0] DEC_B = 2'b01;
    localparam logic [1:0] DEC_C = 2'b10;
    localparam logic [1:0] DEC_D = 2'b11;

    localparam int F_SHOWER  = 0;
    localparam int F_EAT     = 1;
    localparam int F_WALK    = 2;
    localparam int F_NAP     = 3;
    localparam int F_FRIENDS = 4;
    localparam int F_LECTURE = 5;
    localparam int F_VIDEOS  = 6;
    localparam int F_MASK    = 7;

    logic [1:0]        phase;
    logic [4:0]        prev_state;
    logic [STEP_W-1:0] steps;
    logic [7:0]        flags;
    logic              strobe;
    logic              target_met;
    logic              is_event;
    logic [2:0]        ev_idx;
    logic [1:0]        dec_next;

    assign strobe     = (state != prev_state);
    assign target_met = (motivation >= MOT_W'(TARGET_MOT));

    always_comb begin
        is_event = 1'b0;
        ev_idx   = 3'd0;
        case (state)
            5'd3:  begin is_event = 1'b1; ev_idx = 3'(F_SHOWER);  end
            5'd4:  begin is_event = 1'b1; ev_idx = 3'(F_EAT);     end
            5'd5:  begin is_event = 1'b1; ev_idx = 3'(F_WALK);    end
            5'd7:  begin is_event = 1'b1; ev_idx = 3'(F_NAP);     end
            5'd14: begin is_event = 1'b1; ev_idx = 3'(F_FRIENDS); end
            5'd17: begin is_event = 1'b1; ev_idx = 3'(F_LECTURE); end
            5'd18: begin is_event = 1'b1; ev_idx = 3'(F_VIDEOS);  end
            default: ;
        endcase
    end

    // Menu policy: pick the first unfinished motivation source; never A on the phone menu.
    always_comb begin
        dec_next = Decision;
        case (state)
            5'd1: begin
                if (!flags[F_SHOWER])                      dec_next = DEC_B;
                else if (!flags[F_EAT])                    dec_next = DEC_C;
                else if (flags[F_MASK] && !flags[F_WALK])  dec_next = DEC_D;
                else                                       dec_next = DEC_A;
            end
            5'd2: begin
                if (!flags[F_MASK])                        dec_next = DEC_C;
                else if (!flags[F_WALK])                   dec_next = DEC_D;
                else if (!flags[F_NAP])                    dec_next = DEC_B;
                else                                       dec_next = DEC_A;
            end
            5'd6: begin
                if (target_met)                            dec_next = DEC_A;
                else if (!flags[F_FRIENDS])                dec_next = DEC_B;
                else if (!flags[F_LECTURE] || !flags[F_VIDEOS]) dec_next = DEC_C;
                else                                       dec_next = DEC_A;
            end
            5'd11: dec_next = flags[F_FRIENDS] ? DEC_D : DEC_B;
            5'd12: begin
                if (!flags[F_LECTURE])                     dec_next = DEC_A;
                else if (!flags[F_VIDEOS])                 dec_next = DEC_B;
                else                                       dec_next = DEC_D;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase      <= PH_IDLE;
            prev_state <= 5'd0;
            steps      <= '0;
            flags      <= '0;
            Decision   <= DEC_A;
            motivation <= '0;
            done       <= 1'b0;
            win        <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            prev_state <= state;
            case (phase)
                PH_IDLE, PH_DONE: begin
                    if (start) begin
                        phase      <= PH_PLAY;
                        steps      <= '0;
                        flags      <= '0;
                        motivation <= '0;
                        done       <= 1'b0;
                        win        <= 1'b0;
                        timeout    <= 1'b0;
                    end
                end
                PH_PLAY: begin
                    Decision <= dec_next;
                    if (strobe) begin
                        steps <= steps + 1'b1;
                        if (is_event) begin
                            flags[ev_idx] <= 1'b1;
                            if (!flags[ev_idx] && motivation != '1)
                                motivation <= motivation + 1'b1;
                        end
                        if (state == 5'd8)
                            flags[F_MASK] <= 1'b1;
                    end
                    // Terminal states win over the step budget in the same cycle.
                    if (state == 5'd9) begin
                        phase <= PH_DONE;
                        done  <= 1'b1;
                        win   <= 1'b1;
                    end else if (state == 5'd10 || state == 5'd13) begin
                        phase <= PH_DONE;
                        done  <= 1'b1;
                    end else if (strobe && steps == STEP_W'(MAX_STEPS - 1)) begin
                        phase   <= PH_DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_game_autoplayer.sv
// Bench for game_autoplayer: directed scenarios plus random state streams, all outputs
// compared every cycle against a set-based model of the game rules.
module tb_game_autoplayer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [4:0] state = 5'd0;
    logic [1:0] Decision;
    logic [2:0] motivation;
    logic       done, win, timeout;

    int n_checks = 0;
    int n_errors = 0;

    game_autoplayer dut (
        .clk(clk), .reset(reset), .start(start), .state(state),
        .Decision(Decision), .motivation(motivation),
        .done(done), .win(win), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Model: which codes have been visited this game, plus game phase bookkeeping.
    int ev_codes[7] = '{3, 4, 5, 7, 14, 17, 18};
    int pick_main[18] = '{1, 2, 6, 11, 12, 3, 4, 5, 7, 14, 17, 18, 8, 15, 16, 19, 20, 21};
    int pick_rare[6]  = '{9, 10, 13, 0, 22, 31};
    bit seen[32];
    int m_phase;  // 0 idle, 1 play, 2 done
    int m_prev, m_steps, m_dec;
    bit m_done, m_win, m_to;

    function automatic int m_mot();
        int n = 0;
        foreach (ev_codes[i]) if (seen[ev_codes[i]]) n++;
        return (n > 7) ? 7 : n;
    endfunction

    function automatic int m_policy(int s, int cur);
        case (s)
            1:  return !seen[3] ? 1 : !seen[4] ? 2 : (seen[8] && !seen[5]) ? 3 : 0;
            2:  return !seen[8] ? 2 : !seen[5] ? 3 : !seen[7] ? 1 : 0;
            6:  return (m_mot() >= 7) ? 0 : !seen[14] ? 1 : (!seen[17] || !seen[18]) ? 2 : 0;
            11: return seen[14] ? 3 : 1;
            12: return !seen[17] ? 0 : !seen[18] ? 1 : 3;
            default: return cur;
        endcase
    endfunction

    task automatic model_reset();
        foreach (seen[i]) seen[i] = 1'b0;
        m_phase = 0; m_prev = 0; m_steps = 0; m_dec = 0;
        m_done = 0; m_win = 0; m_to = 0;
    endtask

    task automatic model_update(int s, bit st);
        bit strobe = (s != m_prev);
        m_prev = s;
        if (m_phase != 1) begin
            if (st) begin
                foreach (seen[i]) seen[i] = 1'b0;
                m_phase = 1; m_steps = 0; m_done = 0; m_win = 0; m_to = 0;
            end
        end else begin
            m_dec = m_policy(s, m_dec);
            if (strobe) begin
                m_steps++;
                seen[s] = 1'b1;
            end
            if (s == 9) begin
                m_phase = 2; m_done = 1; m_win = 1;
            end else if (s == 10 || s == 13) begin
                m_phase = 2; m_done = 1;
            end else if (strobe && m_steps == 63) begin
                m_phase = 2; m_done = 1; m_to = 1;
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        chk("decision", 32'(Decision), m_dec);
        chk("motivation", 32'(motivation), m_mot());
        chk("done", 32'(done), 32'(m_done));
        chk("win", 32'(win), 32'(m_win));
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic step(int s, bit st);
        @(negedge clk);
        state = 5'(s);
        start = st;
        model_update(s, st);
        @(posedge clk);
        #1;
        start = 1'b0;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        start = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        reset = 1'b1;

        // Reset mid-game with three motivation events recorded.
        step(0, 1);
        step(3, 0); step(4, 0); step(5, 0);
        chk("t1_mot3", 32'(motivation), 3);
        do_reset();
        chk("t1_mot_cleared", 32'(motivation), 0);
        chk("t1_dec_cleared", 32'(Decision), 0);

        // Start, location menu, then a held event counts once.
        step(0, 1);
        step(1, 0);
        chk("t2_dec_b", 32'(Decision), 1);
        repeat (4) step(3, 0);
        chk("t2_mot_once", 32'(motivation), 1);

        step(4, 0);
        step(1, 0);
        chk("t3_loc_a", 32'(Decision), 0);
        step(2, 0);
        chk("t3_bed_c", 32'(Decision), 2);
        step(8, 0);
        step(1, 0);
        chk("t3_loc_d", 32'(Decision), 3);

        step(5, 0); step(7, 0); step(14, 0); step(17, 0); step(18, 0);
        chk("t4_mot7", 32'(motivation), 7);
        step(6, 0);
        chk("t4_desk_a", 32'(Decision), 0);
        step(9, 0);
        chk("t4_done", 32'(done), 1);
        chk("t4_win", 32'(win), 1);

        // Phone menu with friends done must always pick D.
        step(9, 1);
        step(14, 0);
        for (int i = 0; i < 3; i++) begin
            step(11, 0);
            chk("t5_phone_d", 32'(Decision), 3);
            step(15, 0);
        end
        step(13, 0);
        chk("t5_done", 32'(done), 1);
        chk("t5_lose", 32'(win), 0);

        // Step budget: the 63rd strobe ends the game.
        step(13, 1);
        for (int i = 0; i < 63; i++) begin
            step((i % 2) ? 16 : 15, 0);
            if (i == 61) chk("t6_not_yet", 32'(done), 0);
        end
        chk("t6_timeout", 32'(timeout), 1);
        chk("t6_win0", 32'(win), 0);
        step(15, 1);
        chk("t6_restart_done0", 32'(done), 0);
        step(1, 0);
        chk("t6_flags_clear", 32'(Decision), 1);

        for (int i = 0; i < 3000; i++) begin
            int s;
            bit st;
            if ($urandom_range(0, 499) == 0) do_reset();
            if ($urandom_range(0, 2) == 0) s = int'(state);
            else if ($urandom_range(0, 19) == 0) s = pick_rare[$urandom_range(0, 5)];
            else s = pick_main[$urandom_range(0, 17)];
            st = (m_phase != 1) && ($urandom_range(0, 3) == 0);
            step(s, st);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
